// File: rtl/universal_range_counter_pkg.sv
// Shared constants and types for the universal range counter.
// Mode and direction encodings match the raw mode_sat / up input bits.
package universal_range_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // The winning update source on each edge, in descending priority order.
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_CLR,
        SRC_LOAD,
        SRC_FIX,
        SRC_COUNT
    } upd_src_e;

endpackage

// File: rtl/universal_range_counter_next_calc.sv
// Combinational step arithmetic for a count that is known to be inside the window.
// Sums are formed one bit wider than the counter, so nothing wraps silently at 2**N.
module ucnt_next_calc
    import universal_range_counter_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic [N-1:0]      q,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      lim_lo,
    input  logic [N-1:0]      lim_hi,
    input  logic              up,
    input  logic              mode_sat,
    output logic [N-1:0]      q_nxt,
    output logic              hit
);

    logic [N:0] w_step;
    logic [N:0] w_sum;
    logic [N:0] w_downFloor;

    assign w_step      = (N+1)'(step);
    assign w_sum       = {1'b0, q} + w_step;
    // Counting down stays in the window exactly when q - step >= lo, i.e. q >= lo + step.
    assign w_downFloor = {1'b0, lim_lo} + w_step;

    always_comb begin
        q_nxt = q;
        hit   = 1'b0;
        if (step != '0) begin
            if (up == DIR_UP) begin
                if (w_sum <= {1'b0, lim_hi}) begin
                    q_nxt = w_sum[N-1:0];
                end else begin
                    hit   = 1'b1;
                    q_nxt = (mode_sat == MODE_SAT) ? lim_hi : lim_lo;
                end
            end else begin
                if ({1'b0, q} >= w_downFloor) begin
                    q_nxt = q - N'(step);
                end else begin
                    hit   = 1'b1;
                    q_nxt = (mode_sat == MODE_SAT) ? lim_lo : lim_hi;
                end
            end
        end
    end

endmodule

// File: rtl/universal_range_counter.sv
// Up/down counter over a programmable window with wrap or saturate at the limits.
// Holds the count and event flags; step arithmetic lives in ucnt_next_calc.
module universal_range_counter
    import universal_range_counter_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              syn_clr,
    input  logic              load,
    input  logic              en,
    input  logic              up,
    input  logic              mode_sat,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      lim_lo,
    input  logic [N-1:0]      lim_hi,
    input  logic [N-1:0]      d,
    input  logic              clr_ovf,
    output logic [N-1:0]      q,
    output logic              max,
    output logic              min,
    output logic              bnd_evt,
    output logic              ovf_sticky,
    output logic              cfg_err
);

    logic [N-1:0] r_q;
    logic         r_bndEvt;
    logic         r_ovfSticky;

    upd_src_e     w_src;
    logic [N-1:0] w_calcQ;
    logic         w_calcHit;
    logic [N-1:0] w_qNext;
    logic         w_bndNext;
    logic         w_ovfNext;
    logic         w_outOfRange;

    ucnt_next_calc #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_nextCalc (
        .q        (r_q),
        .step     (step),
        .lim_lo   (lim_lo),
        .lim_hi   (lim_hi),
        .up       (up),
        .mode_sat (mode_sat),
        .q_nxt    (w_calcQ),
        .hit      (w_calcHit)
    );

    assign cfg_err      = (lim_lo > lim_hi);
    assign w_outOfRange = (r_q < lim_lo) || (r_q > lim_hi);

    // A bad window freezes the counter entirely until the limits are fixed.
    always_comb begin
        w_src = SRC_HOLD;
        if (cfg_err) begin
            w_src = SRC_HOLD;
        end else if (syn_clr) begin
            w_src = SRC_CLR;
        end else if (load) begin
            w_src = SRC_LOAD;
        end else if (en && w_outOfRange) begin
            w_src = SRC_FIX;
        end else if (en) begin
            w_src = SRC_COUNT;
        end
    end

    always_comb begin
        w_qNext   = r_q;
        w_bndNext = 1'b0;
        case (w_src)
            SRC_CLR:   w_qNext = lim_lo;
            SRC_LOAD: begin
                if (d < lim_lo) begin
                    w_qNext = lim_lo;
                end else if (d > lim_hi) begin
                    w_qNext = lim_hi;
                end else begin
                    w_qNext = d;
                end
            end
            SRC_FIX:   w_qNext = (r_q < lim_lo) ? lim_lo : lim_hi;
            SRC_COUNT: begin
                w_qNext   = w_calcQ;
                w_bndNext = w_calcHit;
            end
            default:   w_qNext = r_q;
        endcase
        // A new boundary event beats a simultaneous clear request.
        w_ovfNext = w_bndNext ? 1'b1 : (clr_ovf ? 1'b0 : r_ovfSticky);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q         <= '0;
            r_bndEvt    <= 1'b0;
            r_ovfSticky <= 1'b0;
        end else begin
            r_q         <= w_qNext;
            r_bndEvt    <= w_bndNext;
            r_ovfSticky <= w_ovfNext;
        end
    end

    assign q          = r_q;
    assign bnd_evt    = r_bndEvt;
    assign ovf_sticky = r_ovfSticky;
    assign max        = (r_q == lim_hi);
    assign min        = (r_q == lim_lo);

endmodule

// File: tb/tb_universal_range_counter.sv
// Scoreboard bench for universal_range_counter: directed scenarios then random traffic
// against an arithmetic reference model of the window counter.
module tb_universal_range_counter;

    localparam int N      = 8;
    localparam int STEP_W = 4;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              syn_clr  = 1'b0;
    logic              load     = 1'b0;
    logic              en       = 1'b0;
    logic              up       = 1'b0;
    logic              mode_sat = 1'b0;
    logic              clr_ovf  = 1'b0;
    logic [STEP_W-1:0] step     = '0;
    logic [N-1:0]      lim_lo   = '0;
    logic [N-1:0]      lim_hi   = '0;
    logic [N-1:0]      d        = '0;
    logic [N-1:0]      q;
    logic              max;
    logic              min;
    logic              bnd_evt;
    logic              ovf_sticky;
    logic              cfg_err;

    typedef struct {
        int q;
        int bnd;
        int ovf;
        int mx;
        int mn;
        int cerr;
    } exp_t;

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   mq   = 0;
    int   mbnd = 0;
    int   movf = 0;

    universal_range_counter #(
        .N      (N),
        .STEP_W (STEP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .syn_clr    (syn_clr),
        .load       (load),
        .en         (en),
        .up         (up),
        .mode_sat   (mode_sat),
        .step       (step),
        .lim_lo     (lim_lo),
        .lim_hi     (lim_hi),
        .d          (d),
        .clr_ovf    (clr_ovf),
        .q          (q),
        .max        (max),
        .min        (min),
        .bnd_evt    (bnd_evt),
        .ovf_sticky (ovf_sticky),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int req);
        nCompared++;
        if (act != req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle of inputs on the falling edge and queues what the next rising edge must produce.
    task automatic applyStimulus(input int iEn, input int iUp, input int iSat, input int iStep,
                                 input int iLo, input int iHi, input int iD,
                                 input int iLoad, input int iClr, input int iClrOvf);
        int   t;
        int   newBnd;
        exp_t e;
        @(negedge clk);
        en       = iEn[0];
        up       = iUp[0];
        mode_sat = iSat[0];
        step     = STEP_W'(iStep);
        lim_lo   = N'(iLo);
        lim_hi   = N'(iHi);
        d        = N'(iD);
        load     = iLoad[0];
        syn_clr  = iClr[0];
        clr_ovf  = iClrOvf[0];

        newBnd = 0;
        if (iLo > iHi) begin
            newBnd = 0;
        end else if (iClr != 0) begin
            mq = iLo;
        end else if (iLoad != 0) begin
            mq = (iD < iLo) ? iLo : ((iD > iHi) ? iHi : iD);
        end else if (iEn != 0) begin
            if (mq < iLo) mq = iLo;
            else if (mq > iHi) mq = iHi;
            else if (iStep != 0) begin
                t = (iUp != 0) ? mq + iStep : mq - iStep;
                if (t > iHi) begin
                    newBnd = 1;
                    mq = (iSat != 0) ? iHi : iLo;
                end else if (t < iLo) begin
                    newBnd = 1;
                    mq = (iSat != 0) ? iLo : iHi;
                end else begin
                    mq = t;
                end
            end
        end
        mbnd = newBnd;
        if (newBnd != 0) movf = 1;
        else if (iClrOvf != 0) movf = 0;

        e.q    = mq;
        e.bnd  = mbnd;
        e.ovf  = movf;
        e.mx   = (mq == iHi) ? 1 : 0;
        e.mn   = (mq == iLo) ? 1 : 0;
        e.cerr = (iLo > iHi) ? 1 : 0;
        expQ.push_back(e);
    endtask

    // Monitor: every queued expectation is checked just after the rising edge it belongs to.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("q",          int'(q),          e.q);
                checkOutput("bnd_evt",    int'(bnd_evt),    e.bnd);
                checkOutput("ovf_sticky", int'(ovf_sticky), e.ovf);
                checkOutput("max",        int'(max),        e.mx);
                checkOutput("min",        int'(min),        e.mn);
                checkOutput("cfg_err",    int'(cfg_err),    e.cerr);
            end
        end
    end

    initial begin
        #200000;
        nMismatched++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rLo;
        int rHi;
        #3;
        checkOutput("reset_q",   int'(q),          0);
        checkOutput("reset_bnd", int'(bnd_evt),    0);
        checkOutput("reset_ovf", int'(ovf_sticky), 0);
        @(negedge clk);
        reset = 1'b1;

        // Wrap upward: 10 -> 13, 16, 19, then wraps to 10 with an event.
        applyStimulus(0, 1, 0, 3, 10, 20, 0, 0, 1, 0);
        repeat (4) applyStimulus(1, 1, 0, 3, 10, 20, 0, 0, 0, 0);

        // Saturate downward from 18: 14, 10, then pinned at 10 with repeated events.
        applyStimulus(0, 0, 1, 4, 10, 20, 18, 1, 0, 0);
        repeat (4) applyStimulus(1, 0, 1, 4, 10, 20, 0, 0, 0, 0);

        // Full 8-bit range wrap from 255 to 0.
        applyStimulus(0, 1, 0, 1, 0, 255, 255, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 255, 0, 0, 0, 0);

        // Load clamping, load with clear, and clear racing against a new event.
        applyStimulus(0, 1, 0, 1, 0, 200, 250, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 50, 200, 120, 1, 1, 0);
        applyStimulus(0, 1, 1, 1, 10, 20, 20, 1, 0, 0);
        applyStimulus(1, 1, 1, 1, 10, 20, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 10, 20, 0, 0, 0, 1);

        // Inverted window freezes the counter; fixing it pulls q up into range.
        applyStimulus(1, 1, 0, 2, 30, 20, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 2, 30, 20, 7, 1, 0, 0);
        applyStimulus(1, 1, 0, 2, 30, 20, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 2, 0, 40, 5, 1, 0, 0);
        applyStimulus(1, 1, 0, 2, 30, 40, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 40, 0, 0, 0, 0);

        // Asynchronous reset mid-count: outputs clear before the next rising edge.
        applyStimulus(0, 1, 1, 1, 0, 255, 8'h37, 1, 0, 0);
        applyStimulus(1, 1, 0, 15, 0, 255, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 15, 0, 255, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        load  = 1'b0;
        en    = 1'b0;
        reset = 1'b0;
        mq    = 0;
        mbnd  = 0;
        movf  = 0;
        #1;
        checkOutput("async_q",   int'(q),          0);
        checkOutput("async_bnd", int'(bnd_evt),    0);
        checkOutput("async_ovf", int'(ovf_sticky), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) applyStimulus(1, 1, 0, 1, 0, 255, 0, 0, 0, 0);

        // Random traffic with occasional limit changes, including inverted windows.
        rLo = 10;
        rHi = 60;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                rLo = $urandom_range(0, 200);
                rHi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                                  : rLo + $urandom_range(0, 55);
            end
            applyStimulus(($urandom_range(0, 9) < 8) ? 1 : 0,
                          $urandom_range(0, 1),
                          $urandom_range(0, 1),
                          $urandom_range(0, 15),
                          rLo, rHi,
                          $urandom_range(0, 255),
                          ($urandom_range(0, 19) == 0) ? 1 : 0,
                          ($urandom_range(0, 29) == 0) ? 1 : 0,
                          ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
